reg_wb_scoreboard: RTL and testbench

- Parametrised successor to the register write-enable decoder.
- Tracks every register write from issue to writeback through a WB_LAT-deep pipeline, then drives the one-hot register-file write enables at writeback.
- Keeps a per-register pending-write scoreboard and raises a RAW stall to the issue stage.
- Sits between decode/issue and the register file; supports pipeline flush and an optional read-only zero register.

---
 rtl/reg_wb_scoreboard.sv | 121 ++++++++++++
 tb/tb_reg_wb_scoreboard.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/reg_wb_scoreboard.sv
// Register writeback tracker: carries accepted writes through a WB_LAT-deep pipeline,
// drives one-hot register-file write enables at writeback and flags RAW hazards at issue.
module reg_wb_scoreboard #(
    parameter int NUM_REGS = 4,
    parameter int ADDR_W   = 2,
    parameter int WB_LAT   = 2,
    parameter bit ZERO_RO  = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                issue_valid,
    input  logic [ADDR_W-1:0]   rd,
    input  logic                bne,
    input  logic                empty_inst,
    input  logic [ADDR_W-1:0]   rs1,
    input  logic                rs1_used,
    input  logic [ADDR_W-1:0]   rs2,
    input  logic                rs2_used,
    input  logic                flush,
    output logic                stall,
    output logic [NUM_REGS-1:0] reg_en,
    output logic                wb_valid,
    output logic [ADDR_W-1:0]   wb_rd,
    output logic [NUM_REGS-1:0] busy
);

    // At most WB_LAT writes can be in flight, so the counter needs to hold WB_LAT.
    localparam int CNT_W = $clog2(WB_LAT + 1);

    logic [WB_LAT-1:0] r_stg_valid;
    logic [ADDR_W-1:0] r_stg_rd [WB_LAT];
    logic [CNT_W-1:0]  r_count  [NUM_REGS];

    logic                w_write;
    logic                w_rd_hardwired;
    logic                w_rs1_hit;
    logic                w_rs2_hit;
    logic                w_stall;
    logic                w_accept;
    logic                w_enter;
    logic                w_wb_valid;
    logic [ADDR_W-1:0]   w_wb_rd;
    logic [NUM_REGS-1:0] w_busy;
    logic [NUM_REGS-1:0] w_inc;
    logic [NUM_REGS-1:0] w_dec;

    assign w_write        = issue_valid & ~bne & ~empty_inst;
    assign w_rd_hardwired = ZERO_RO && (rd == '0);

    // No bypass: a register committing this cycle still reads as busy.
    assign w_rs1_hit = rs1_used & w_busy[rs1] & ~(ZERO_RO && (rs1 == '0));
    assign w_rs2_hit = rs2_used & w_busy[rs2] & ~(ZERO_RO && (rs2 == '0));
    assign w_stall   = w_rs1_hit | w_rs2_hit;

    // Writes to a hard-wired zero register are accepted but travel as bubbles.
    assign w_accept = w_write & ~w_stall & ~flush;
    assign w_enter  = w_accept & ~w_rd_hardwired;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stg_valid <= '0;
            for (int s = 0; s < WB_LAT; s++) begin
                r_stg_rd[s] <= '0;
            end
        end else begin
            r_stg_valid[0] <= w_enter;
            r_stg_rd[0]    <= rd;
            for (int s = 1; s < WB_LAT; s++) begin
                r_stg_valid[s] <= r_stg_valid[s-1] & ~flush;
                r_stg_rd[s]    <= r_stg_rd[s-1];
            end
        end
    end

    assign w_wb_valid = r_stg_valid[WB_LAT-1];
    assign w_wb_rd    = w_wb_valid ? r_stg_rd[WB_LAT-1] : '0;

    always_comb begin
        w_inc = '0;
        w_dec = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            w_inc[i] = w_enter    && (rd      == ADDR_W'(i));
            w_dec[i] = w_wb_valid && (w_wb_rd == ADDR_W'(i));
        end
    end

    // Flush empties every stage but the committing one, so all counts return to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_count[i] <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_count[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                case ({w_inc[i], w_dec[i]})
                    2'b10:   r_count[i] <= r_count[i] + CNT_W'(1);
                    2'b01:   r_count[i] <= r_count[i] - CNT_W'(1);
                    default: r_count[i] <= r_count[i];
                endcase
            end
        end
    end

    always_comb begin
        w_busy = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            w_busy[i] = (r_count[i] != '0);
        end
    end

    assign stall    = w_stall;
    assign busy     = w_busy;
    assign wb_valid = w_wb_valid;
    assign wb_rd    = w_wb_rd;
    assign reg_en   = w_wb_valid ? (NUM_REGS'(1) << w_wb_rd) : '0;

endmodule

// File: tb/tb_reg_wb_scoreboard.sv
// Randomized scoreboard bench for reg_wb_scoreboard; three configurations share one stimulus stream.
module tb_reg_wb_scoreboard;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n       = 1'b1;
    logic       issue_valid = 1'b0;
    logic       bne         = 1'b0;
    logic       empty_inst  = 1'b0;
    logic       flush       = 1'b0;
    logic       rs1_used    = 1'b0;
    logic       rs2_used    = 1'b0;
    logic [1:0] rd          = 2'd0;
    logic [1:0] rs1         = 2'd0;
    logic [1:0] rs2         = 2'd0;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [1:0] rd;
        int         age;
    } wr_t;

    task automatic chk(input string name, input int inst, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s unit%0d t=%0t actual=%0h required=%0h", name, inst, $time, act, exp);
        end
    endtask

    for (genvar gi = 0; gi < 3; gi++) begin : g_u
        localparam int LAT = (gi == 0) ? 2 : ((gi == 1) ? 3 : 1);
        localparam bit ZRO = (gi == 1);

        logic       st;
        logic       wv;
        logic [1:0] wrd;
        logic [3:0] ren;
        logic [3:0] bsy;

        reg_wb_scoreboard #(
            .NUM_REGS(4),
            .ADDR_W  (2),
            .WB_LAT  (LAT),
            .ZERO_RO (ZRO)
        ) dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .issue_valid(issue_valid),
            .rd         (rd),
            .bne        (bne),
            .empty_inst (empty_inst),
            .rs1        (rs1),
            .rs1_used   (rs1_used),
            .rs2        (rs2),
            .rs2_used   (rs2_used),
            .flush      (flush),
            .stall      (st),
            .reg_en     (ren),
            .wb_valid   (wv),
            .wb_rd      (wrd),
            .busy       (bsy)
        );

        // Reference: ordered list of in-flight writes, each aging one per cycle.
        wr_t q[$];

        always @(negedge clk) begin
            logic [3:0] eb;
            logic [3:0] onehot;
            logic       es;
            logic       ecommit;
            wr_t        h;
            if (!rst_n) begin
                q.delete();
                chk("rst_reg_en",   gi, int'(ren), 0);
                chk("rst_wb_valid", gi, int'(wv),  0);
                chk("rst_wb_rd",    gi, int'(wrd), 0);
                chk("rst_busy",     gi, int'(bsy), 0);
                chk("rst_stall",    gi, int'(st),  0);
            end else begin
                eb = 4'b0000;
                foreach (q[i]) eb[q[i].rd] = 1'b1;
                es = (rs1_used && eb[rs1] && !(ZRO && rs1 == 2'd0)) ||
                     (rs2_used && eb[rs2] && !(ZRO && rs2 == 2'd0));
                ecommit = (q.size() > 0) && (q[0].age == LAT - 1);
                chk("busy",     gi, int'(bsy), int'(eb));
                chk("stall",    gi, int'(st),  int'(es));
                chk("wb_valid", gi, int'(wv),  int'(ecommit));
                if (wv && q.size() > 0) begin
                    h = q.pop_front();
                    onehot = 4'b0001;
                    onehot = onehot << h.rd;
                    chk("wb_rd",  gi, int'(wrd), int'(h.rd));
                    chk("reg_en", gi, int'(ren), int'(onehot));
                    $display("unit%0d commit rd=%0d reg_en=%b t=%0t", gi, wrd, ren, $time);
                end else if (!wv) begin
                    chk("reg_en_idle", gi, int'(ren), 0);
                end
                while (q.size() > 0 && q[0].age >= LAT - 1) void'(q.pop_front());
                foreach (q[i]) q[i].age++;
                if (flush) begin
                    q.delete();
                end else if (issue_valid && !bne && !empty_inst && !es &&
                             !(ZRO && rd == 2'd0)) begin
                    h.rd  = rd;
                    h.age = 0;
                    q.push_back(h);
                end
            end
        end
    end

    task automatic drive(input logic iv, input logic [1:0] d, input logic b, input logic e,
                         input logic [1:0] s1, input logic u1, input logic [1:0] s2,
                         input logic u2, input logic f);
        @(posedge clk);
        #1;
        issue_valid = iv;
        rd          = d;
        bne         = b;
        empty_inst  = e;
        rs1         = s1;
        rs1_used    = u1;
        rs2         = s2;
        rs2_used    = u2;
        flush       = f;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        drive(1, 2, 0, 0, 0, 0, 0, 0, 0);
        idle(4);
        drive(1, 3, 1, 0, 0, 0, 0, 0, 0);
        drive(1, 3, 0, 1, 0, 0, 0, 0, 0);
        idle(5);
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) drive(1, 2, 0, 0, 1, 1, 0, 0, 0);
        idle(4);
        drive(1, 3, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 3, 0, 0, 0, 0, 0, 0, 0);
        idle(5);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(4);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 2, 0, 0, 0, 1, 0, 0, 0);
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(3);

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 149) == 0) begin
                @(posedge clk);
                #1 rst_n = 1'b0;
                @(posedge clk);
                #1 rst_n = 1'b1;
            end else begin
                drive($urandom_range(0, 9) < 7,
                      2'($urandom_range(0, 3)),
                      $urandom_range(0, 7) == 0,
                      $urandom_range(0, 7) == 0,
                      2'($urandom_range(0, 3)),
                      $urandom_range(0, 1) == 1,
                      2'($urandom_range(0, 3)),
                      $urandom_range(0, 1) == 1,
                      $urandom_range(0, 19) == 0);
            end
        end
        idle(6);
        @(posedge clk);
        #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
